// File: rtl/awb_gain_controller_if.sv
// Pixel-stream tap shared with color_balance: RGB data, pixel qualifier and
// frame-end strobe.
interface awb_gain_controller_if;
  logic [23:0] rgb_in;
  logic        rgb_in_valid;
  logic        frame_end;

  modport master (output rgb_in, output rgb_in_valid, output frame_end);
  modport slave  (input  rgb_in, input  rgb_in_valid, input  frame_end);
endinterface

// File: rtl/awb_gain_controller.sv
// Frame-rate auto-white-balance: per-frame channel sums feed a short FSM that
// moves red/blue gains one LSB per frame toward green, committed in one cycle.
module awb_gain_controller #(
  parameter int GAIN_W    = 4,
  parameter int GAIN_INIT = 4,
  parameter int GAIN_MIN  = 1,
  parameter int GAIN_MAX  = 15,
  parameter int ACC_W     = 32,
  parameter int DB_SHIFT  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  awb_gain_controller_if.slave  pix,
  input  logic                  awb_en,
  output logic [GAIN_W-1:0]     gain_red,
  output logic [GAIN_W-1:0]     gain_green,
  output logic [GAIN_W-1:0]     gain_blue,
  output logic                  gain_update,
  output logic                  busy,
  output logic                  frame_dropped
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CMP_R  = 2'd1;
  localparam logic [1:0] CMP_B  = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  localparam logic [GAIN_W-1:0] G_INIT = GAIN_W'(GAIN_INIT);
  localparam logic [GAIN_W-1:0] G_MIN  = GAIN_W'(GAIN_MIN);
  localparam logic [GAIN_W-1:0] G_MAX  = GAIN_W'(GAIN_MAX);

  logic [1:0]        state_q, state_d;
  logic [ACC_W-1:0]  acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;
  logic [ACC_W-1:0]  s_r_q, s_r_d, s_g_q, s_g_d, s_b_q, s_b_d;
  logic [ACC_W-1:0]  sum_r, sum_g, sum_b;
  logic [GAIN_W-1:0] gain_red_q, gain_red_d, gain_blue_q, gain_blue_d;
  logic [GAIN_W-1:0] next_r_q, next_r_d, next_b_q, next_b_d;
  logic              gain_update_q, gain_update_d;
  logic              frame_dropped_q, frame_dropped_d;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [7:0]       b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W-7){1'b0}}, b};
    sat_add = s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  // One extra bit keeps channel + deadband from overflowing in the compares.
  function automatic logic [GAIN_W-1:0] step_gain(input logic [ACC_W-1:0]  s_c,
                                                  input logic [ACC_W-1:0]  s_ref,
                                                  input logic [GAIN_W-1:0] g);
    logic [ACC_W:0] c, r, db;
    c  = {1'b0, s_c};
    r  = {1'b0, s_ref};
    db = {1'b0, s_ref >> DB_SHIFT};
    step_gain = g;
    if (c + db < r) begin
      step_gain = (g >= G_MAX) ? G_MAX : g + GAIN_W'(1);
    end else if (c > r + db) begin
      step_gain = (g <= G_MIN) ? G_MIN : g - GAIN_W'(1);
    end
  endfunction

  always_comb begin
    sum_r = acc_r_q;
    sum_g = acc_g_q;
    sum_b = acc_b_q;
    if (pix.rgb_in_valid) begin
      sum_r = sat_add(acc_r_q, pix.rgb_in[23:16]);
      sum_g = sat_add(acc_g_q, pix.rgb_in[15:8]);
      sum_b = sat_add(acc_b_q, pix.rgb_in[7:0]);
    end
  end

  // The frame_end pixel belongs to the ending frame, so snapshots take the
  // post-add sums while accumulators restart from zero.
  always_comb begin
    acc_r_d         = pix.frame_end ? '0 : sum_r;
    acc_g_d         = pix.frame_end ? '0 : sum_g;
    acc_b_d         = pix.frame_end ? '0 : sum_b;
    s_r_d           = s_r_q;
    s_g_d           = s_g_q;
    s_b_d           = s_b_q;
    state_d         = state_q;
    next_r_d        = next_r_q;
    next_b_d        = next_b_q;
    gain_red_d      = gain_red_q;
    gain_blue_d     = gain_blue_q;
    gain_update_d   = 1'b0;
    frame_dropped_d = pix.frame_end && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (pix.frame_end) begin
          s_r_d   = sum_r;
          s_g_d   = sum_g;
          s_b_d   = sum_b;
          state_d = CMP_R;
        end
      end
      CMP_R: begin
        next_r_d = step_gain(s_r_q, s_g_q, gain_red_q);
        state_d  = CMP_B;
      end
      CMP_B: begin
        next_b_d = step_gain(s_b_q, s_g_q, gain_blue_q);
        state_d  = COMMIT;
      end
      default: begin
        if (awb_en) begin
          gain_red_d    = next_r_q;
          gain_blue_d   = next_b_q;
          gain_update_d = 1'b1;
        end
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      acc_r_q         <= '0;
      acc_g_q         <= '0;
      acc_b_q         <= '0;
      s_r_q           <= '0;
      s_g_q           <= '0;
      s_b_q           <= '0;
      next_r_q        <= G_INIT;
      next_b_q        <= G_INIT;
      gain_red_q      <= G_INIT;
      gain_blue_q     <= G_INIT;
      gain_update_q   <= 1'b0;
      frame_dropped_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_r_q         <= acc_r_d;
      acc_g_q         <= acc_g_d;
      acc_b_q         <= acc_b_d;
      s_r_q           <= s_r_d;
      s_g_q           <= s_g_d;
      s_b_q           <= s_b_d;
      next_r_q        <= next_r_d;
      next_b_q        <= next_b_d;
      gain_red_q      <= gain_red_d;
      gain_blue_q     <= gain_blue_d;
      gain_update_q   <= gain_update_d;
      frame_dropped_q <= frame_dropped_d;
    end
  end

  assign gain_red      = gain_red_q;
  assign gain_green    = G_INIT;
  assign gain_blue     = gain_blue_q;
  assign gain_update   = gain_update_q;
  assign busy          = (state_q != IDLE);
  assign frame_dropped = frame_dropped_q;

endmodule

// File: tb/tb_awb_gain_controller.sv
// Scoreboarded bench: stimulus queues expected {red,green,blue} per commit,
// monitors pop on every gain_update pulse of each DUT instance.
module tb_awb_gain_controller;

  logic clk = 1'b0;
  logic rst, rst2, awb_en, awb_en2;
  logic [3:0] gr1, gg1, gb1, gr2, gg2, gb2;
  logic upd1, upd2, busy1, busy2, drop1, drop2;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [11:0] exp_q1[$];
  logic [11:0] exp_q2[$];

  awb_gain_controller_if if1();
  awb_gain_controller_if if2();

  always #5 clk = ~clk;

  awb_gain_controller #(.GAIN_W(4), .GAIN_INIT(4), .GAIN_MIN(1), .GAIN_MAX(15),
                        .ACC_W(32), .DB_SHIFT(3)) dut (
    .clk(clk), .rst(rst), .pix(if1), .awb_en(awb_en),
    .gain_red(gr1), .gain_green(gg1), .gain_blue(gb1),
    .gain_update(upd1), .busy(busy1), .frame_dropped(drop1));

  awb_gain_controller #(.GAIN_W(4), .GAIN_INIT(4), .GAIN_MIN(1), .GAIN_MAX(15),
                        .ACC_W(16), .DB_SHIFT(3)) dut16 (
    .clk(clk), .rst(rst2), .pix(if2), .awb_en(awb_en2),
    .gain_red(gr2), .gain_green(gg2), .gain_blue(gb2),
    .gain_update(upd2), .busy(busy2), .frame_dropped(drop2));

  always @(negedge clk) begin
    logic [11:0] e;
    if (upd1) begin
      total_cnt++;
      if (exp_q1.size() == 0) begin
        $display("FAIL upd32: unexpected gain_update, gains %0d/%0d/%0d, required no pulse",
                 gr1, gg1, gb1);
      end else begin
        e = exp_q1.pop_front();
        if ({gr1, gg1, gb1} == e) pass_cnt++;
        else $display("FAIL upd32: gains %0d/%0d/%0d, required %0d/%0d/%0d",
                      gr1, gg1, gb1, e[11:8], e[7:4], e[3:0]);
      end
    end
  end

  always @(negedge clk) begin
    logic [11:0] e;
    if (upd2) begin
      total_cnt++;
      if (exp_q2.size() == 0) begin
        $display("FAIL upd16: unexpected gain_update, gains %0d/%0d/%0d, required no pulse",
                 gr2, gg2, gb2);
      end else begin
        e = exp_q2.pop_front();
        if ({gr2, gg2, gb2} == e) pass_cnt++;
        else $display("FAIL upd16: gains %0d/%0d/%0d, required %0d/%0d/%0d",
                      gr2, gg2, gb2, e[11:8], e[7:4], e[3:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic drive(input bit d2, input logic v, input logic [23:0] pix,
                       input logic fe);
    if (d2) begin
      if2.rgb_in_valid = v; if2.rgb_in = pix; if2.frame_end = fe;
    end else begin
      if1.rgb_in_valid = v; if1.rgb_in = pix; if1.frame_end = fe;
    end
  endtask

  // Ends at T+1 (one cycle after the frame_end cycle).
  task automatic frame(input bit d2, input int n, input logic [23:0] pix);
    for (int i = 0; i < n; i++) begin
      drive(d2, 1'b1, pix, (i == n - 1));
      step();
    end
    drive(d2, 1'b0, 24'h0, 1'b0);
  endtask

  // From T+1: busy must cover T+1..T+3, clear at T+4; ends at T+5.
  task automatic commit_seq(input string tag, input bit d2);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("%s_busy_T%0d", tag, k), d2 ? busy2 : busy1, 1);
      step();
    end
    chk($sformatf("%s_busy_T4", tag), d2 ? busy2 : busy1, 0);
    step();
  endtask

  task automatic reset1();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; awb_en = 1'b1; awb_en2 = 1'b1;
    drive(1'b0, 1'b0, 24'h0, 1'b0);
    drive(1'b1, 1'b0, 24'h0, 1'b0);
    step(); step();
    rst = 1'b0; rst2 = 1'b0;

    chk("rst_red", gr1, 4);
    chk("rst_green", gg1, 4);
    chk("rst_blue", gb1, 4);
    chk("rst_update", upd1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_dropped", drop1, 0);

    // Balanced grey: commit with unchanged gains still pulses.
    exp_q1.push_back({4'd4, 4'd4, 4'd4});
    frame(1'b0, 100, 24'h808080);
    commit_seq("t1", 1'b0);

    // Warm scene: red steps down to GAIN_MIN, blue up one per frame.
    reset1();
    exp_q1.push_back({4'd3, 4'd4, 4'd5});
    exp_q1.push_back({4'd2, 4'd4, 4'd6});
    exp_q1.push_back({4'd1, 4'd4, 4'd7});
    exp_q1.push_back({4'd1, 4'd4, 4'd8});
    for (int f = 0; f < 4; f++) begin
      frame(1'b0, 100, 24'hC08040);
      commit_seq("t2", 1'b0);
    end

    // Deadband hold, black frame hold, tiny red on black decrements.
    reset1();
    exp_q1.push_back({4'd4, 4'd4, 4'd4});
    frame(1'b0, 100, 24'h888080);
    commit_seq("t3", 1'b0);
    exp_q1.push_back({4'd4, 4'd4, 4'd4});
    frame(1'b0, 4, 24'h000000);
    commit_seq("t3blk", 1'b0);
    exp_q1.push_back({4'd3, 4'd4, 4'd4});
    frame(1'b0, 4, 24'h010000);
    commit_seq("t3red", 1'b0);

    // Second frame_end at T+2 is dropped; its red pixels must not leak.
    reset1();
    exp_q1.push_back({4'd3, 4'd4, 4'd5});
    frame(1'b0, 100, 24'hC08040);
    chk("t4_drop_T1", drop1, 0);
    drive(1'b0, 1'b1, 24'hFF0000, 1'b0);
    step();
    chk("t4_drop_T2", drop1, 0);
    drive(1'b0, 1'b1, 24'hFF0000, 1'b1);
    step();
    drive(1'b0, 1'b0, 24'h0, 1'b0);
    chk("t4_drop_T3", drop1, 1);
    chk("t4_busy_T3", busy1, 1);
    step();
    chk("t4_drop_T4", drop1, 0);
    chk("t4_busy_T4", busy1, 0);
    step();
    exp_q1.push_back({4'd3, 4'd4, 4'd5});
    frame(1'b0, 8, 24'h808080);
    commit_seq("t4b", 1'b0);

    // Frozen gains, then re-enable.
    reset1();
    awb_en = 1'b0;
    frame(1'b0, 100, 24'hC08080);
    repeat (5) step();
    chk("t5_red_frozen", gr1, 4);
    chk("t5_blue_frozen", gb1, 4);
    awb_en = 1'b1;
    exp_q1.push_back({4'd3, 4'd4, 4'd4});
    frame(1'b0, 100, 24'hC08080);
    commit_seq("t5", 1'b0);

    // 16-bit accumulators saturate rather than wrap.
    exp_q2.push_back({4'd4, 4'd4, 4'd4});
    frame(1'b1, 300, 24'hFFFFFF);
    commit_seq("t6w", 1'b1);
    exp_q2.push_back({4'd3, 4'd4, 4'd3});
    frame(1'b1, 300, 24'hFFC0FF);
    commit_seq("t6s", 1'b1);
    frame(1'b1, 300, 24'hFFC0FF);
    step();
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    chk("t6_busy_after_rst", busy2, 0);
    chk("t6_red_after_rst", gr2, 4);
    chk("t6_blue_after_rst", gb2, 4);
    repeat (4) step();
    chk("t6_red_later", gr2, 4);
    chk("t6_blue_later", gb2, 4);

    chk("pending_q1", exp_q1.size(), 0);
    chk("pending_q2", exp_q2.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
